hwpe_tcdm_responder: RTL and testbench



---
 rtl/hwpe_tcdm_responder.sv | 161 ++++++++++++++++
 tb/tb_hwpe_tcdm_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_tcdm_responder.sv
// Banked, word-interleaved TCDM slave with per-bank round-robin arbitration and 1-cycle latency.
// Optional per-bank pseudo-random stall injection: define HWPE_TCDM_RESPONDER_STALL_EN.
`timescale 1ns/1ps

module hwpe_tcdm_responder #(
  parameter int unsigned NB_PORTS   = 6,
  parameter int unsigned NB_BANKS   = 8,
  parameter int unsigned BANK_WORDS = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NB_PORTS-1:0]       tcdm_req,
  output logic [NB_PORTS-1:0]       tcdm_gnt,
  input  logic [NB_PORTS-1:0][31:0] tcdm_add,
  input  logic [NB_PORTS-1:0]       tcdm_wen,
  input  logic [NB_PORTS-1:0][3:0]  tcdm_be,
  input  logic [NB_PORTS-1:0][31:0] tcdm_data,
  output logic [NB_PORTS-1:0][31:0] tcdm_r_data,
  output logic [NB_PORTS-1:0]       tcdm_r_valid
);

  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int unsigned BW = $clog2(NB_BANKS);
  localparam int unsigned RW = $clog2(BANK_WORDS);

  typedef logic [PW-1:0] port_idx_t;

  // Port index base+off, wrapping at NB_PORTS (base is always < NB_PORTS).
  function automatic port_idx_t rr_next(input port_idx_t base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NB_PORTS) sum = sum - NB_PORTS;
    return PW'(sum);
  endfunction

  logic [NB_PORTS-1:0][BW-1:0]      port_bank;
  logic [NB_PORTS-1:0][RW-1:0]      port_row;
  logic [NB_BANKS-1:0][NB_PORTS-1:0] bank_req;
  logic [NB_BANKS-1:0]              bank_act;
  logic [NB_BANKS-1:0]              bank_fire;
  logic [NB_BANKS-1:0][PW-1:0]      bank_win;
  logic [NB_BANKS-1:0][PW-1:0]      ptr;
  logic [NB_BANKS-1:0]              bank_stall;
  logic [NB_PORTS-1:0]              port_gnt;
  logic [NB_PORTS-1:0]              valid_q;
  logic [NB_PORTS-1:0][31:0]        rdata_q;
  logic [31:0]                      mem [NB_BANKS][BANK_WORDS];
  logic                             unused_add;

  // Byte offset and row bits above the bank array alias, so they are deliberately dropped.
  assign unused_add = ^tcdm_add;

  always_comb begin
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      port_bank[p] = tcdm_add[p][2 +: BW];
      port_row[p]  = tcdm_add[p][2 + BW +: RW];
    end
  end

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int p = 0; p < NB_PORTS; p++) begin
        bank_req[b][p] = tcdm_req[p] && (port_bank[p] == BW'(b));
      end
    end
  end

  // Each bank scans ports from its pointer upward; the first requester it meets wins.
  always_comb begin
    port_idx_t idx;
    idx      = '0;
    bank_act = '0;
    bank_win = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int k = 0; k < NB_PORTS; k++) begin
        idx = rr_next(ptr[b], k);
        if (!bank_act[b] && !bank_stall[b] && bank_req[b][idx]) begin
          bank_act[b] = 1'b1;
          bank_win[b] = idx;
        end
      end
    end
  end

  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int p = 0; p < NB_PORTS; p++) begin
        if (bank_act[b] && (bank_win[b] == PW'(p))) port_gnt[p] = 1'b1;
      end
    end
  end

  assign tcdm_gnt  = port_gnt & {NB_PORTS{rst_n}};
  assign bank_fire = bank_act & {NB_BANKS{rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      for (int b = 0; b < NB_BANKS; b++) begin
        if (bank_fire[b]) ptr[b] <= rr_next(bank_win[b], 1);
      end
    end
  end

  // Memory survives reset; writes only happen on a real grant.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB_BANKS; b++) begin
      if (bank_fire[b] && !tcdm_wen[bank_win[b]]) begin
        for (int i = 0; i < 4; i++) begin
          if (tcdm_be[bank_win[b]][i]) begin
            mem[b][port_row[bank_win[b]]][8*i +: 8] <= tcdm_data[bank_win[b]][8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < NB_PORTS; p++) begin
        valid_q[p] <= port_gnt[p];
        rdata_q[p] <= (port_gnt[p] && tcdm_wen[p]) ? mem[port_bank[p]][port_row[p]] : 32'h0;
      end
    end
  end

  // Masking with rst_n drops a response already in flight when reset arrives.
  assign tcdm_r_valid = valid_q & {NB_PORTS{rst_n}};
  assign tcdm_r_data  = rst_n ? rdata_q : '0;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
  logic [NB_BANKS-1:0][15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; a set LSB blocks the bank for that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NB_BANKS; b++) lfsr[b] <= 16'hACE1 + 16'(b);
    end else begin
      for (int b = 0; b < NB_BANKS; b++) begin
        lfsr[b] <= {lfsr[b][0] ^ lfsr[b][2] ^ lfsr[b][3] ^ lfsr[b][5], lfsr[b][15:1]};
      end
    end
  end

  always_comb begin
    bank_stall = '0;
    for (int b = 0; b < NB_BANKS; b++) bank_stall[b] = lfsr[b][0];
  end
`else
  assign bank_stall = '0;
`endif

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Scoreboard bench for hwpe_tcdm_responder: directed vectors push expected responses, a monitor checks them.
`timescale 1ns/1ps

module tb_hwpe_tcdm_responder;

  localparam int NB_PORTS = 6;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic                      clk;
  logic                      rst_n;
  logic [NB_PORTS-1:0]       req;
  logic [NB_PORTS-1:0]       gnt;
  logic [NB_PORTS-1:0][31:0] add;
  logic [NB_PORTS-1:0]       wen;
  logic [NB_PORTS-1:0][3:0]  be;
  logic [NB_PORTS-1:0][31:0] wdata;
  logic [NB_PORTS-1:0][31:0] r_data;
  logic [NB_PORTS-1:0]       r_valid;

  resp_t exp_q [NB_PORTS][$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  logic [NB_PORTS-1:0][31:0] er;

  hwpe_tcdm_responder #(.NB_PORTS(6), .NB_BANKS(8), .BANK_WORDS(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tcdm_req    (req),
    .tcdm_gnt    (gnt),
    .tcdm_add    (add),
    .tcdm_wen    (wen),
    .tcdm_be     (be),
    .tcdm_data   (wdata),
    .tcdm_r_data (r_data),
    .tcdm_r_valid(r_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic setPort(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
    req[p]   = 1'b1;
    wen[p]   = w;
    add[p]   = a;
    be[p]    = b;
    wdata[p] = d;
  endtask

  // Called at posedge+1 with inputs set; checks grants, queues the responses, drops granted reqs.
  task automatic applyStimulus(input logic [NB_PORTS-1:0] exp_gnt, input logic [NB_PORTS-1:0][31:0] exp_rd,
                               input string name);
    logic [NB_PORTS-1:0] g;
    #3;
    g = gnt;
    checkOutput({name, " gnt"}, 32'(g), 32'(exp_gnt));
    for (int p = 0; p < NB_PORTS; p++) begin
      if (g[p]) exp_q[p].push_back('{data: (wen[p] ? exp_rd[p] : 32'h0), due: cyc + 1});
    end
    @(posedge clk);
    #1;
    req = req & ~g;
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NB_PORTS; p++) begin
      if (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL p%0d missing r_valid: got 0, expected 1 at cycle %0d", p, exp_q[p][0].due);
        void'(exp_q[p].pop_front());
      end
      if (r_valid[p]) begin
        if (exp_q[p].size() == 0) begin
          checkOutput($sformatf("p%0d unexpected r_valid", p), 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = exp_q[p].pop_front();
          checkOutput($sformatf("p%0d r_data", p), r_data[p], r.data);
          checkOutput($sformatf("p%0d latency", p), 32'(cyc), 32'(r.due));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wen   = '0;
    add   = '0;
    be    = '0;
    wdata = '0;
    er    = '0;
    repeat (3) @(posedge clk);
    #1;

    // Requests during reset must not be granted nor produce responses.
    setPort(0, 1'b0, 32'h100, 4'hF, 32'h12345678);
    repeat (2) begin
      #2;
      checkOutput("reset r_valid", 32'(r_valid), 32'd0);
      #(-0);
      applyStimulus(6'b000000, er, "reset");
    end
    req   = '0;
    rst_n = 1'b1;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
    begin
      logic [15:0] m;
      logic        written;
      m       = 16'hACE1;
      written = 1'b0;
      for (int i = 0; i < 200; i++) begin
        logic [NB_PORTS-1:0] eg;
        setPort(0, written, 32'h0, 4'hF, 32'h5A5A0000);
        eg    = '0;
        eg[0] = ~m[0];
        er    = '0;
        er[0] = 32'h5A5A0000;
        applyStimulus(eg, er, "stall");
        if (eg[0]) written = 1'b1;
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      end
      req = '0;
    end
`else
    // Single write then read.
    setPort(0, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF);
    er = '0;
    applyStimulus(6'b000001, er, "wr 0x100");
    setPort(0, 1'b1, 32'h100, 4'hF, 32'h0);
    er[0] = 32'hDEADBEEF;
    applyStimulus(6'b000001, er, "rd 0x100");

    // Byte enables, including an all-zero mask that must still respond.
    setPort(0, 1'b0, 32'h40, 4'hF, 32'h11223344);
    applyStimulus(6'b000001, er, "wr 0x40");
    setPort(0, 1'b0, 32'h40, 4'b0101, 32'hAABBCCDD);
    applyStimulus(6'b000001, er, "wr 0x40 be0101");
    setPort(0, 1'b1, 32'h40, 4'hF, 32'h0);
    er[0] = 32'h11BB33DD;
    applyStimulus(6'b000001, er, "rd 0x40");
    setPort(0, 1'b0, 32'h40, 4'h0, 32'hFFFFFFFF);
    applyStimulus(6'b000001, er, "wr 0x40 be0000");
    setPort(0, 1'b1, 32'h40, 4'hF, 32'h0);
    applyStimulus(6'b000001, er, "rd 0x40 again");

    // Six ports, six banks, all in one cycle.
    for (int p = 0; p < NB_PORTS; p++) setPort(p, 1'b0, 32'(4 * p), 4'hF, 32'h10000000 + 32'(p));
    applyStimulus(6'b111111, er, "parallel wr");
    for (int p = 0; p < NB_PORTS; p++) begin
      setPort(p, 1'b1, 32'(4 * p), 4'hF, 32'h0);
      er[p] = 32'h10000000 + 32'(p);
    end
    applyStimulus(6'b111111, er, "parallel rd");

    // Reset arrives the cycle after a granted read: the response is dropped.
    er = '0;
    setPort(0, 1'b1, 32'h4, 4'hF, 32'h0);
    er[0] = 32'h10000001;
    applyStimulus(6'b000001, er, "rd before reset");
    rst_n = 1'b0;
    for (int p = 0; p < NB_PORTS; p++) exp_q[p].delete();
    #2;
    checkOutput("mid-reset r_valid", 32'(r_valid), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setPort(0, 1'b1, 32'h4, 4'hF, 32'h0);
    applyStimulus(6'b000001, er, "rd after reset");

    // Three ports on bank 0: served in round-robin order.
    er = '0;
    for (int p = 0; p < 3; p++) begin
      setPort(p, 1'b1, 32'h0, 4'hF, 32'h0);
      er[p] = 32'h10000000;
    end
    applyStimulus(6'b000001, er, "conflict c1");
    applyStimulus(6'b000010, er, "conflict c2");
    applyStimulus(6'b000100, er, "conflict c3");

    // Pointer wrap: pointer at 3, ports 0 and 5 compete.
    er[5] = 32'h10000000;
    setPort(0, 1'b1, 32'h0, 4'hF, 32'h0);
    setPort(5, 1'b1, 32'h0, 4'hF, 32'h0);
    applyStimulus(6'b100000, er, "wrap c1");
    applyStimulus(6'b000001, er, "wrap c2");
    setPort(0, 1'b1, 32'h0, 4'hF, 32'h0);
    setPort(5, 1'b1, 32'h0, 4'hF, 32'h0);
    applyStimulus(6'b100000, er, "wrap c3");
    applyStimulus(6'b000001, er, "wrap c4");

    // Back-to-back reads from one port.
    for (int i = 0; i < 4; i++) begin
      setPort(0, 1'b1, 32'(4 * i), 4'hF, 32'h0);
      er[0] = 32'h10000000 + 32'(i);
      applyStimulus(6'b000001, er, "b2b rd");
    end

    // Read right after write to the same row, then via an aliased address.
    setPort(1, 1'b0, 32'h20, 4'hF, 32'hCAFEF00D);
    applyStimulus(6'b000010, er, "wr 0x20");
    setPort(2, 1'b1, 32'h20, 4'hF, 32'h0);
    er[2] = 32'hCAFEF00D;
    applyStimulus(6'b000100, er, "raw rd 0x20");
    setPort(3, 1'b1, 32'h8020, 4'hF, 32'h0);
    er[3] = 32'hCAFEF00D;
    applyStimulus(6'b001000, er, "alias rd 0x8020");

    // Write and read on different banks in the same cycle.
    setPort(3, 1'b0, 32'h24, 4'hF, 32'h01234567);
    setPort(4, 1'b1, 32'h20, 4'hF, 32'h0);
    er[4] = 32'hCAFEF00D;
    applyStimulus(6'b011000, er, "mixed banks");
    setPort(5, 1'b1, 32'h24, 4'hF, 32'h0);
    er[5] = 32'h01234567;
    applyStimulus(6'b100000, er, "rd 0x24");
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NB_PORTS; p++) checkOutput($sformatf("p%0d drained", p), 32'(exp_q[p].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
